ecc_enc: RTL and testbench
==========================

// Module: ecc_enc
// PURPOSE
//  Parameterised extended-Hamming (SECDED) encoder for the memory write path; produces codewords ecc_dec consumes.
//  Streaming valid/ready interface, 0-2 register stages, and a one-shot error-injection FSM for system-level ECC test.
//  Sits between the write-data source and the RAM/interconnect; codeword layout is bit-exact with ecc_dec.
// PARAMETERS
//  K        8             information bits per word
//  LATENCY  0             0: combinational; 1: registered output; 2: registered input+output
//  P0_LSB   1             1: overall parity p0 at codeword bit 0; 0: p0 at bit n
//  m        calc_m(K)     check bits; smallest m with 2**m >= m+K+1 (localparam in spirit, never override)
//  n        m+K           highest codeword position; codeword width n+1
// PORTS
//  clk_i        in   1      clock
//  rstn_i       in   1      asynchronous reset, active-low
//  d_i          in   K      information word
//  valid_i      in   1      d_i valid
//  ready_o      out  1      encoder accepts d_i this cycle
//  q_o          out  n+1    encoded codeword, P0_LSB ordering applied
//  valid_o      out  1      q_o valid
//  ready_i      in   1      sink accepts q_o this cycle
//  inj_arm_i    in   1      pulse: arm one-shot error injection
//  inj_mask_i   in   n+1    XOR mask in q_o bit ordering, sampled with inj_arm_i
//  inj_busy_o   out  1      injection armed, not yet applied
// BEHAVIOUR
//  Encoding: positions 1..n; power-of-two positions are check bits p(2**j), others carry d_i.
//   Information bits fill positions in ascending order, LSB first (d_i[0] at position 3).
//   p(2**j) = XOR of all positions i with bit j of i set (i != 2**j). p0 = XOR of positions 1..n (even overall parity).
//   P0_LSB=1: q = cw[n:0]; P0_LSB=0: q = {cw[0], cw[n:1]}.
//  Handshake: transfer on valid&ready at each port. Data/valid never change while valid_o=1 and ready_i=0.
//   LATENCY 0: q_o/valid_o combinational from d_i/valid_i; ready_o = ready_i.
//   LATENCY 1: one output stage; ready_o = ~valid_o | ready_i. 1 cycle in->out, full throughput, no bubble.
//   LATENCY 2: input stage (raw d_i) + output stage (encoded); each stage ready = ~stage_valid | downstream_ready.
//    2 cycles in->out; full throughput under continuous ready_i; no overflow or drop under arbitrary backpressure.
//  Injection FSM, states IDLE/ARMED:
//   IDLE & inj_arm_i & ~accept -> ARMED, capture inj_mask_i.
//   IDLE & inj_arm_i & accept (valid_i&ready_o) -> mask applies to that beat; stay IDLE.
//   ARMED & accept -> mask tags that beat; -> IDLE. ARMED & inj_arm_i -> ignored, mask unchanged.
//   Mask travels with its beat through the stages; XOR applied after encoding, immediately before q_o.
//   Zero mask still consumes the arm. inj_busy_o = (state==ARMED).
//  Reset values: valid_o=0, q_o=0, inj_busy_o=0, all stage valids=0, captured mask=0, state=IDLE.
//   ready_o is not a reset value (combinational): after reset ready_o=1 for LATENCY>0, and = ready_i for LATENCY 0.
//  Reset mid-operation: in-flight beats and a pending injection are discarded; no partial beat after rstn_i rises.
//  Width rules: all check/parity math is unsigned XOR reduction; no truncation; q_o exactly n+1 bits.
// STRUCTURE
//  ecc_pkg: calc_m(), is_pow2(), cw_build() (data->positions), check/p0 functions, inj_state_t enum {IDLE, ARMED}.
//   Share calc_m, extraction order and P0_LSB ordering with ecc_dec to keep layouts identical.
//  Sub-module ecc_pipe_slice: one valid/ready register stage, payload width parameter.
//   Instantiated 0/1/2 times via generate; payload = {mask, data-or-codeword}.
// TESTING
//  K=8 (m=4, n=12), P0_LSB=1, LATENCY=1: d_i=8'h00 -> q_o=13'h0000, one cycle later.
//  Same config: d_i=8'hFF -> q_o=13'h1EEE; d_i=8'h01 -> q_o=13'h000F.
//  P0_LSB=0: d_i=8'hFF -> q_o=13'h0F77. Then loopback all 256 words through ecc_dec -> q==d, no error flags.
//  LATENCY=2, random valid_i/ready_i (50%), 10k beats -> in-order, no loss/duplication, q_o stable while stalled.
//  Arm with mask=13'h0010, then send 3 beats -> only the first beat's q_o has bit 4 flipped.
//   ecc_dec then reports sb_err_o=1, sb_fix_o=1, q corrected. inj_busy_o falls the cycle after that accept.
//  Arm with mask=13'h0006 while ARMED; then assert rstn_i=0 mid-stream -> valid_o=0 and inj_busy_o=0 at once.
//   Next beats are clean; a later double-bit inject gives ecc_dec db_err_o=1.

Source files
------------

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared definitions for the SECDED encoder (and its matching decoder).
//  - calc_m()     : number of Hamming check bits for K information bits
//  - is_pow2()    : identifies check-bit positions
//  - cw_build()   : scatters information bits onto non-power-of-two positions
//  - ecc_encode() : fills check bits p(2**j) and overall parity p0
//  - ecc_order()  : applies the P0_LSB output ordering
//  - inj_state_t  : one-shot error-injection FSM states
// Functions work on a fixed maximum codeword width so they can be shared by
// any K; callers zero-extend inputs and size-cast the results.
package ecc_pkg;

    localparam int MAX_W = 64;    // largest supported codeword width (n+1)
    localparam int MAX_M = 7;     // loop bound for check-bit index
    localparam int AW    = 6;     // bits needed to index MAX_W positions

    typedef enum logic {
        IDLE,
        ARMED
    } inj_state_t;

    function automatic int calc_m(input int k);
        int m = 0;
        while ((1 << m) < (m + k + 1)) m++;
        return m;
    endfunction

    function automatic logic is_pow2(input int i);
        return (i > 0) && ((i & (i - 1)) == 0);
    endfunction

    // Information bits land on positions 3,5,6,7,9,... in ascending order, LSB first.
    function automatic logic [MAX_W-1:0] cw_build(input logic [MAX_W-1:0] d, input int n);
        logic [MAX_W-1:0] cw;
        int               j;
        cw = '0;
        j  = 0;
        for (int i = 1; i < MAX_W; i++) begin
            if (i <= n && !is_pow2(i)) begin
                cw[i[AW-1:0]] = d[j[AW-1:0]];
                j++;
            end
        end
        return cw;
    endfunction

    function automatic logic ecc_p0(input logic [MAX_W-1:0] cw);
        // bits above n and bit 0 are zero when this is called
        return ^cw;
    endfunction

    function automatic logic [MAX_W-1:0] ecc_encode(input logic [MAX_W-1:0] d, input int n, input int m);
        logic [MAX_W-1:0] cw;
        logic             p;
        int               pos;
        cw = cw_build(d, n);
        for (int b = 0; b < MAX_M; b++) begin
            if (b < m) begin
                p   = 1'b0;
                pos = 1 << b;
                for (int i = 1; i < MAX_W; i++) begin
                    if (i <= n && ((i >> b) & 1) == 1 && i != pos)
                        p = p ^ cw[i[AW-1:0]];
                end
                cw[pos[AW-1:0]] = p;
            end
        end
        cw[0] = ecc_p0(cw);
        return cw;
    endfunction

    // p0_lsb=0 moves p0 from bit 0 up to bit n: q = {cw[0], cw[n:1]}.
    function automatic logic [MAX_W-1:0] ecc_order(input logic [MAX_W-1:0] cw, input int n, input int p0_lsb);
        logic [MAX_W-1:0] q;
        if (p0_lsb != 0) return cw;
        q             = cw >> 1;
        q[n[AW-1:0]]  = cw[0];
        return q;
    endfunction

endpackage

// File: rtl/ecc_enc_if.sv
// ecc_enc_if: valid/ready stream bundle used on both sides of the encoder.
//  data  : payload, W bits
//  valid : payload valid (driven by master)
//  ready : sink accepts this cycle (driven by slave)
interface ecc_enc_if #(
    parameter int W = 8
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ecc_pipe_slice.sv
// ecc_pipe_slice: one valid/ready register stage with full throughput.
//  clk_i, rstn_i        : clock, asynchronous active-low reset
//  in_data/in_valid     : upstream payload
//  in_ready             : stage can take a beat (empty, or draining this cycle)
//  out_data/out_valid   : registered payload, held stable while stalled
//  out_ready            : downstream accepts
module ecc_pipe_slice #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] data_reg;
    logic         valid_reg;

    assign in_ready  = ~valid_reg | out_ready;
    assign out_data  = data_reg;
    assign out_valid = valid_reg;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (in_ready) begin
            valid_reg <= in_valid;
            // payload only moves on a real beat so a stalled output never changes
            if (in_valid) data_reg <= in_data;
        end
    end

endmodule

// File: rtl/ecc_enc.sv
// ecc_enc: extended-Hamming (SECDED) encoder with valid/ready streaming,
// 0..2 register stages and a one-shot error-injection FSM.
//  clk_i, rstn_i : clock, asynchronous active-low reset
//  in_if         : slave stream, data = K information bits
//  out_if        : master stream, data = n+1 bit codeword (P0_LSB ordering)
//  inj_arm_i     : pulse, arms a one-shot XOR injection
//  inj_mask_i    : XOR mask in output bit ordering, sampled with inj_arm_i
//  inj_busy_o    : injection armed but not yet attached to a beat
module ecc_enc
    import ecc_pkg::*;
#(
    parameter  int K       = 8,
    parameter  int LATENCY = 0,
    parameter  int P0_LSB  = 1,
    localparam int M       = calc_m(K),
    localparam int N       = M + K,
    localparam int W       = N + 1
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    ecc_enc_if.slave     in_if,
    ecc_enc_if.master    out_if,
    input  logic         inj_arm_i,
    input  logic [W-1:0] inj_mask_i,
    output logic         inj_busy_o
);

    inj_state_t     state_reg, state_next;
    logic [W-1:0]   mask_reg, mask_next;
    logic [W-1:0]   beat_mask;
    logic           accept;

    logic [W+K-1:0] mid_pay;
    logic [K-1:0]   mid_data;
    logic [W-1:0]   mid_mask;
    logic           mid_valid, mid_ready;
    logic [W-1:0]   enc_cw;
    logic [2*W-1:0] out_pay;

    assign accept = in_if.valid & in_if.ready;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= IDLE;
            mask_reg  <= '0;
        end else begin
            state_reg <= state_next;
            mask_reg  <= mask_next;
        end
    end

    // beat_mask is the mask that rides along with the beat accepted this cycle
    always_comb begin
        state_next = state_reg;
        mask_next  = mask_reg;
        beat_mask  = '0;
        case (state_reg)
            IDLE: begin
                if (inj_arm_i) begin
                    if (accept) begin
                        beat_mask = inj_mask_i;
                    end else begin
                        state_next = ARMED;
                        mask_next  = inj_mask_i;
                    end
                end
            end
            ARMED: begin
                if (accept) begin
                    beat_mask  = mask_reg;
                    state_next = IDLE;
                    mask_next  = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign inj_busy_o = (state_reg == ARMED);

    // Input stage carries raw data so the encoder logic sits between registers.
    generate
        if (LATENCY == 2) begin : g_in_stage
            ecc_pipe_slice #(.W(W + K)) u_in_slice (
                .clk_i     (clk_i),
                .rstn_i    (rstn_i),
                .in_data   ({beat_mask, in_if.data}),
                .in_valid  (in_if.valid),
                .in_ready  (in_if.ready),
                .out_data  (mid_pay),
                .out_valid (mid_valid),
                .out_ready (mid_ready)
            );
        end else begin : g_in_bypass
            assign mid_pay     = {beat_mask, in_if.data};
            assign mid_valid   = in_if.valid;
            assign in_if.ready = mid_ready;
        end
    endgenerate

    assign mid_data = mid_pay[K-1:0];
    assign mid_mask = mid_pay[W+K-1:K];
    assign enc_cw   = W'(ecc_order(ecc_encode(MAX_W'(mid_data), N, M), N, P0_LSB));

    generate
        if (LATENCY >= 1) begin : g_out_stage
            ecc_pipe_slice #(.W(2 * W)) u_out_slice (
                .clk_i     (clk_i),
                .rstn_i    (rstn_i),
                .in_data   ({mid_mask, enc_cw}),
                .in_valid  (mid_valid),
                .in_ready  (mid_ready),
                .out_data  (out_pay),
                .out_valid (out_if.valid),
                .out_ready (out_if.ready)
            );
        end else begin : g_out_bypass
            assign out_pay      = {mid_mask, enc_cw};
            assign out_if.valid = mid_valid;
            assign mid_ready    = out_if.ready;
        end
    endgenerate

    // Injection is applied last so the mask is in q_o bit ordering.
    assign out_if.data = out_pay[W-1:0] ^ out_pay[2*W-1:W];

endmodule

// File: tb/tb_ecc_enc.sv
// tb_ecc_enc: randomized self-checking bench for ecc_enc (K=8, n=12).
//  u_a: LATENCY=1, P0_LSB=1  (known vectors, injection, reset mid-stream)
//  u_b: LATENCY=2, P0_LSB=0  (loopback of all words, random backpressure stress)
//  u_c: LATENCY=0, P0_LSB=1  (combinational path)
// The reference encoder picks check bits so that the XOR of the indices of
// all set positions is zero; the reference decoder uses the syndrome.
module tb_ecc_enc;

    localparam int K = 8;
    localparam int W = 13;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    ecc_enc_if #(.W(K)) a_in ();
    ecc_enc_if #(.W(W)) a_out ();
    ecc_enc_if #(.W(K)) b_in ();
    ecc_enc_if #(.W(W)) b_out ();
    ecc_enc_if #(.W(K)) c_in ();
    ecc_enc_if #(.W(W)) c_out ();

    logic         a_arm, b_arm, c_arm;
    logic [W-1:0] a_mask, b_mask, c_mask;
    logic         a_busy, b_busy, c_busy;

    ecc_enc #(.K(K), .LATENCY(1), .P0_LSB(1)) u_a (
        .clk_i(clk), .rstn_i(rstn), .in_if(a_in), .out_if(a_out),
        .inj_arm_i(a_arm), .inj_mask_i(a_mask), .inj_busy_o(a_busy));
    ecc_enc #(.K(K), .LATENCY(2), .P0_LSB(0)) u_b (
        .clk_i(clk), .rstn_i(rstn), .in_if(b_in), .out_if(b_out),
        .inj_arm_i(b_arm), .inj_mask_i(b_mask), .inj_busy_o(b_busy));
    ecc_enc #(.K(K), .LATENCY(0), .P0_LSB(1)) u_c (
        .clk_i(clk), .rstn_i(rstn), .in_if(c_in), .out_if(c_out),
        .inj_arm_i(c_arm), .inj_mask_i(c_mask), .inj_busy_o(c_busy));

    function automatic logic [12:0] ref_encode(input logic [7:0] d, input bit p0lsb);
        logic [12:0] cw;
        int          s, j;
        cw = '0; s = 0; j = 0;
        for (int i = 1; i <= 12; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (d[j]) begin
                    cw[i] = 1'b1;
                    s = s ^ i;
                end
                j++;
            end
        end
        for (int b = 0; b < 4; b++) cw[1 << b] = s[b];
        cw[0] = ^cw;
        if (p0lsb) return cw;
        return {cw[0], cw[12:1]};
    endfunction

    task automatic ref_decode(input logic [12:0] q, input bit p0lsb,
                              output logic [7:0] d, output bit sb, output bit db);
        logic [12:0] cw;
        int          syn, j;
        cw  = p0lsb ? q : {q[11:0], q[12]};
        syn = 0;
        for (int i = 1; i <= 12; i++) if (cw[i]) syn = syn ^ i;
        sb = 1'b0; db = 1'b0;
        if (^cw) begin
            sb = 1'b1;
            if (syn <= 12) cw[syn] = ~cw[syn];
        end else if (syn != 0) begin
            db = 1'b1;
        end
        d = '0; j = 0;
        for (int i = 1; i <= 12; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[j] = cw[i];
                j++;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (a_out.valid !== 1'b0) begin fails++; $display("FAIL reset_valid_o: got %b want 0", a_out.valid); end
        tests++; if (a_out.data !== 13'h0) begin fails++; $display("FAIL reset_q_o: got %h want 0000", a_out.data); end
        tests++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b%b want 00", a_busy, b_busy); end
        rstn = 1'b1;
        #1;
        tests++; if (a_in.ready !== 1'b1 || b_in.ready !== 1'b1) begin fails++; $display("FAIL reset_ready_o: got %b%b want 11", a_in.ready, b_in.ready); end
        tests++; if (b_out.valid !== 1'b0) begin fails++; $display("FAIL reset_b_valid: got %b want 0", b_out.valid); end
        c_out.ready = 1'b0; #1;
        tests++; if (c_in.ready !== 1'b0) begin fails++; $display("FAIL lat0_ready_low: got %b want 0", c_in.ready); end
        c_out.ready = 1'b1; #1;
        tests++; if (c_in.ready !== 1'b1 || c_busy !== 1'b0) begin fails++; $display("FAIL lat0_ready_high: got %b busy %b want 1 0", c_in.ready, c_busy); end
    endtask

    task automatic test_vectors();
        logic [7:0]  dv [11];
        logic [12:0] kv [3];
        dv[0] = 8'h00; dv[1] = 8'hFF; dv[2] = 8'h01;
        kv[0] = 13'h0000; kv[1] = 13'h1EEE; kv[2] = 13'h000F;
        for (int i = 3; i < 11; i++) dv[i] = 8'($urandom);
        a_out.ready = 1'b1;
        for (int i = 0; i <= 11; i++) begin
            @(negedge clk);
            if (i > 0) begin
                tests++;
                if (a_out.valid !== 1'b1 || a_out.data !== ref_encode(dv[i-1], 1'b1)) begin
                    fails++; $display("FAIL lat1_encode d=%h: got v=%b q=%h want v=1 q=%h", dv[i-1], a_out.valid, a_out.data, ref_encode(dv[i-1], 1'b1));
                end
                if (i <= 3) begin
                    tests++;
                    if (a_out.data !== kv[i-1]) begin fails++; $display("FAIL known_vector d=%h: got %h want %h", dv[i-1], a_out.data, kv[i-1]); end
                end
            end
            if (i < 11) begin
                a_in.data = dv[i]; a_in.valid = 1'b1;
            end else begin
                a_in.valid = 1'b0;
            end
            if (i == 0) begin
                #1;
                tests++; if (a_out.valid !== 1'b0) begin fails++; $display("FAIL lat1_not_comb: got v=%b want 0", a_out.valid); end
            end
        end
        @(negedge clk);
        tests++; if (a_out.valid !== 1'b0) begin fails++; $display("FAIL lat1_drain: got v=%b want 0", a_out.valid); end
    endtask

    task automatic test_comb();
        logic [7:0] d;
        c_out.ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            d = 8'($urandom);
            c_in.data = d; c_in.valid = 1'b1;
            #1;
            tests++;
            if (c_out.valid !== 1'b1 || c_out.data !== ref_encode(d, 1'b1)) begin
                fails++; $display("FAIL lat0_encode d=%h: got v=%b q=%h want v=1 q=%h", d, c_out.valid, c_out.data, ref_encode(d, 1'b1));
            end
        end
        c_in.valid = 1'b0; #1;
        tests++; if (c_out.valid !== 1'b0) begin fails++; $display("FAIL lat0_valid_follow: got %b want 0", c_out.valid); end
    endtask

    // Streams nbeats through u_b; rnd selects random data and 50% valid/ready.
    task automatic test_stream(input int nbeats, input bit rnd, input int budget);
        logic [7:0]  exp_q [$];
        logic [7:0]  d, dd;
        logic [12:0] e, held;
        int          sent, got, cyc;
        bit          hold, acc_in, sb, db;
        sent = 0; got = 0; cyc = 0; hold = 0; acc_in = 0; held = '0;
        b_in.valid = 1'b0;
        while (got < nbeats && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                tests++;
                if (b_out.valid !== 1'b1 || b_out.data !== held) begin
                    fails++; $display("FAIL stall_stable: got v=%b q=%h want v=1 q=%h", b_out.valid, b_out.data, held);
                end
            end
            if (!b_in.valid || acc_in) begin
                if (sent < nbeats && (!rnd || $urandom_range(1, 0) == 1)) begin
                    b_in.valid = 1'b1;
                    b_in.data  = rnd ? 8'($urandom) : 8'(sent);
                end else begin
                    b_in.valid = 1'b0;
                end
            end
            b_out.ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            #1;
            acc_in = b_in.valid && b_in.ready;
            if (acc_in) begin
                exp_q.push_back(b_in.data);
                sent++;
            end
            if (b_out.valid && b_out.ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL stream_extra_beat: got q=%h with nothing outstanding", b_out.data);
                end else begin
                    d = exp_q.pop_front();
                    e = ref_encode(d, 1'b0);
                    if (b_out.data !== e) begin
                        fails++; $display("FAIL stream_order beat %0d: got %h want %h", got, b_out.data, e);
                    end
                    ref_decode(b_out.data, 1'b0, dd, sb, db);
                    tests++;
                    if (dd !== d || sb || db) begin
                        fails++; $display("FAIL loopback d=%h: got d=%h sb=%b db=%b want d=%h sb=0 db=0", d, dd, sb, db, d);
                    end
                    if (!rnd && d == 8'hFF) begin
                        tests++;
                        if (b_out.data !== 13'h0F77) begin fails++; $display("FAIL p0_msb_vector: got %h want 0f77", b_out.data); end
                    end
                end
                got++;
            end
            hold = b_out.valid && !b_out.ready;
            held = b_out.data;
        end
        b_in.valid  = 1'b0;
        b_out.ready = 1'b1;
        tests++;
        if (got != nbeats) begin fails++; $display("FAIL stream_count: got %0d beats want %0d in %0d cycles", got, nbeats, budget); end
        if (!rnd) begin
            tests++;
            if (cyc > nbeats + 4) begin fails++; $display("FAIL throughput: took %0d cycles want <= %0d", cyc, nbeats + 4); end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (b_out.valid !== 1'b0) begin fails++; $display("FAIL stream_duplicate: got v=%b q=%h want v=0", b_out.valid, b_out.data); end
        end
    endtask

    task automatic test_inject();
        logic [7:0]  dv [3];
        logic [7:0]  dd, x;
        logic [12:0] e;
        bit          sb, db;
        a_out.ready = 1'b1; a_in.valid = 1'b0;
        for (int i = 0; i < 3; i++) dv[i] = 8'($urandom);

        // single-bit mask tags only the first following beat
        @(negedge clk); a_arm = 1'b1; a_mask = 13'h0010;
        @(negedge clk); a_arm = 1'b0;
        tests++; if (a_busy !== 1'b1) begin fails++; $display("FAIL inj_armed: got busy=%b want 1", a_busy); end
        a_in.data = dv[0]; a_in.valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = ref_encode(dv[i], 1'b1) ^ ((i == 0) ? 13'h0010 : 13'h0000);
            tests++;
            if (a_out.valid !== 1'b1 || a_out.data !== e) begin fails++; $display("FAIL inj_beat%0d: got q=%h want %h", i, a_out.data, e); end
            if (i == 0) begin
                tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL inj_busy_fall: got busy=%b want 0", a_busy); end
                ref_decode(a_out.data, 1'b1, dd, sb, db);
                tests++;
                if (!sb || db || dd !== dv[0]) begin fails++; $display("FAIL inj_sb_fix: got d=%h sb=%b db=%b want d=%h sb=1 db=0", dd, sb, db, dv[0]); end
            end
            if (i < 2) a_in.data = dv[i+1];
            else a_in.valid = 1'b0;
        end

        // re-arm while ARMED is ignored; double-bit mask is detected
        @(negedge clk); a_arm = 1'b1; a_mask = 13'h0006;
        @(negedge clk); a_mask = 13'h0010;
        @(negedge clk); a_arm = 1'b0;
        x = 8'($urandom); a_in.data = x; a_in.valid = 1'b1;
        @(negedge clk); a_in.valid = 1'b0;
        e = ref_encode(x, 1'b1) ^ 13'h0006;
        tests++; if (a_out.data !== e || a_busy !== 1'b0) begin fails++; $display("FAIL inj_rearm_ignored: got q=%h busy=%b want q=%h busy=0", a_out.data, a_busy, e); end
        ref_decode(a_out.data, 1'b1, dd, sb, db);
        tests++; if (!db || sb) begin fails++; $display("FAIL inj_db_err: got sb=%b db=%b want sb=0 db=1", sb, db); end

        // arm and accept in the same cycle: applies to that beat, stays IDLE
        @(negedge clk); a_arm = 1'b1; a_mask = 13'h0100; x = 8'($urandom); a_in.data = x; a_in.valid = 1'b1;
        @(negedge clk); a_arm = 1'b0; a_in.valid = 1'b0;
        e = ref_encode(x, 1'b1) ^ 13'h0100;
        tests++; if (a_out.data !== e || a_busy !== 1'b0) begin fails++; $display("FAIL inj_same_cycle: got q=%h busy=%b want q=%h busy=0", a_out.data, a_busy, e); end

        // zero mask still consumes the arm
        @(negedge clk); a_arm = 1'b1; a_mask = 13'h0000;
        @(negedge clk); a_arm = 1'b0;
        tests++; if (a_busy !== 1'b1) begin fails++; $display("FAIL inj_zero_arm: got busy=%b want 1", a_busy); end
        x = 8'($urandom); a_in.data = x; a_in.valid = 1'b1;
        @(negedge clk); a_in.valid = 1'b0;
        tests++; if (a_out.data !== ref_encode(x, 1'b1) || a_busy !== 1'b0) begin fails++; $display("FAIL inj_zero_consume: got q=%h busy=%b want q=%h busy=0", a_out.data, a_busy, ref_encode(x, 1'b1)); end

        // reset while a beat is stalled and an injection is pending
        @(negedge clk); a_out.ready = 1'b0; a_in.data = 8'($urandom); a_in.valid = 1'b1;
        @(negedge clk); a_in.valid = 1'b0; a_arm = 1'b1; a_mask = 13'h0010;
        @(negedge clk); a_mask = 13'h0006;
        @(negedge clk); a_arm = 1'b0;
        tests++; if (a_busy !== 1'b1 || a_out.valid !== 1'b1) begin fails++; $display("FAIL pre_reset_state: got busy=%b v=%b want 1 1", a_busy, a_out.valid); end
        #2 rstn = 1'b0;
        #1;
        tests++; if (a_out.valid !== 1'b0 || a_busy !== 1'b0 || a_out.data !== 13'h0) begin fails++; $display("FAIL async_reset: got v=%b busy=%b q=%h want 0 0 0000", a_out.valid, a_busy, a_out.data); end
        @(negedge clk); rstn = 1'b1; a_out.ready = 1'b1;
        @(negedge clk);
        tests++; if (a_out.valid !== 1'b0) begin fails++; $display("FAIL post_reset_no_beat: got v=%b want 0", a_out.valid); end
        x = 8'($urandom); a_in.data = x; a_in.valid = 1'b1;
        @(negedge clk); a_in.valid = 1'b0;
        ref_decode(a_out.data, 1'b1, dd, sb, db);
        tests++; if (a_out.data !== ref_encode(x, 1'b1) || sb || db) begin fails++; $display("FAIL post_reset_clean: got q=%h sb=%b db=%b want q=%h clean", a_out.data, sb, db, ref_encode(x, 1'b1)); end
    endtask

    initial begin
        a_in.data = '0; a_in.valid = 1'b0; a_out.ready = 1'b1;
        b_in.data = '0; b_in.valid = 1'b0; b_out.ready = 1'b1;
        c_in.data = '0; c_in.valid = 1'b0; c_out.ready = 1'b1;
        a_arm = 1'b0; b_arm = 1'b0; c_arm = 1'b0;
        a_mask = '0; b_mask = '0; c_mask = '0;
        test_reset();
        test_vectors();
        test_comb();
        test_stream(256, 1'b0, 400);
        test_stream(10000, 1'b1, 60000);
        test_inject();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
